// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 8-digit 7-segment scan controller with frame-synchronous value commit
module display_scan_ctrl #(
  parameter int PRESCALE = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] value,
  input  logic [7:0]  blank_mask,
  input  logic        lz_en,
  output logic        busy,
  output logic        ack,
  output logic [2:0]  contador,
  output logic [31:0] digitos,
  output logic [7:0]  anodo
);

  localparam int PW = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    contador_q, contador_d;
  logic [31:0]   digitos_q, digitos_d;
  logic [31:0]   hold_q, hold_d;
  logic          busy_q, busy_d;
  logic          ack_q, ack_d;
  logic [7:0]    anodo_q, anodo_d;

  logic          tick;
  logic          boundary;
  logic          zero_run;
  logic [7:0]    upper_zero;
  logic          blanked;

  always_comb begin
    tick       = (presc_q == PRESC_MAX);
    presc_d    = tick ? '0 : presc_q + PW'(1);
    contador_d = tick ? contador_q + 3'd1 : contador_q;
    boundary   = tick && (contador_q == 3'd7);

    digitos_d = digitos_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    ack_d     = 1'b0;

    // A load landing on the boundary bypasses hold so the newest value wins.
    if (boundary && load) begin
      digitos_d = value;
      ack_d     = 1'b1;
      busy_d    = 1'b0;
    end else if (boundary && busy_q) begin
      digitos_d = hold_q;
      ack_d     = 1'b1;
      busy_d    = 1'b0;
    end else if (load) begin
      hold_d = value;
      busy_d = 1'b1;
    end

    // upper_zero[k]: digits k..7 of the next shadow value are all zero.
    zero_run   = 1'b1;
    upper_zero = '0;
    for (int k = 7; k >= 0; k--) begin
      zero_run      = zero_run & (digitos_d[4*k +: 4] == 4'd0);
      upper_zero[k] = zero_run;
    end

    blanked = blank_mask[contador_d] |
              (lz_en & (contador_d != 3'd0) & upper_zero[contador_d]);
    anodo_d = blanked ? 8'hFF : ~(8'b1 << contador_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q    <= '0;
      contador_q <= 3'd0;
      digitos_q  <= 32'd0;
      hold_q     <= 32'd0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      anodo_q    <= 8'hFF;
    end else begin
      presc_q    <= presc_d;
      contador_q <= contador_d;
      digitos_q  <= digitos_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      anodo_q    <= anodo_d;
    end
  end

  assign busy     = busy_q;
  assign ack      = ack_q;
  assign contador = contador_q;
  assign digitos  = digitos_q;
  assign anodo    = anodo_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - randomized and directed bench for display_scan_ctrl against a slot-arithmetic model
module tb_display_scan_ctrl;
  localparam int P = 4;
  localparam int FRAME = 8 * P;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load;
  logic [31:0] value;
  logic [7:0]  blank_mask;
  logic        lz_en;
  logic        busy;
  logic        ack;
  logic [2:0]  contador;
  logic [31:0] digitos;
  logic [7:0]  anodo;

  int errors = 0;
  int checks = 0;

  // Model: edges since reset release, displayed value, pending hold.
  int          n_m;
  logic [31:0] shown_m;
  logic [31:0] hold_m;
  bit          pend_m;
  bit          ack_m;
  bit          in_reset_m;

  display_scan_ctrl #(.PRESCALE(P)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .value     (value),
    .blank_mask(blank_mask),
    .lz_en     (lz_en),
    .busy      (busy),
    .ack       (ack),
    .contador  (contador),
    .digitos   (digitos),
    .anodo     (anodo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int slot_m();
    return (n_m / P) % 8;
  endfunction

  function automatic logic [7:0] exp_anodo();
    int k;
    if (in_reset_m) return 8'hFF;
    k = slot_m();
    if (blank_mask[k] || (lz_en && k != 0 && (shown_m >> (4 * k)) == 32'd0)) return 8'hFF;
    return ~(8'b1 << k);
  endfunction

  task automatic check_all();
    check("busy", 32'(busy), 32'(pend_m));
    check("ack", 32'(ack), 32'(ack_m));
    check("contador", 32'(contador), 32'(slot_m()));
    check("digitos", digitos, shown_m);
    check("anodo", 32'(anodo), 32'(exp_anodo()));
  endtask

  task automatic model_reset();
    n_m     = 0;
    shown_m = 32'd0;
    hold_m  = 32'd0;
    pend_m  = 1'b0;
    ack_m   = 1'b0;
  endtask

  task automatic step(input bit ld, input logic [31:0] v);
    bit bnd;
    load  = ld;
    value = v;
    @(posedge clk);
    bnd = (n_m % FRAME) == FRAME - 1;
    if (bnd && ld) begin
      shown_m = v;
      ack_m   = 1'b1;
      pend_m  = 1'b0;
    end else if (bnd && pend_m) begin
      shown_m = hold_m;
      ack_m   = 1'b1;
      pend_m  = 1'b0;
    end else if (ld) begin
      hold_m = v;
      pend_m = 1'b1;
      ack_m  = 1'b0;
    end else begin
      ack_m = 1'b0;
    end
    n_m++;
    #1;
    load = 1'b0;
    check_all();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 32'd0);
  endtask

  task automatic idle_to_slot(input int s);
    for (int i = 0; i < 2 * FRAME && slot_m() != s; i++) step(1'b0, 32'd0);
  endtask

  task automatic idle_to_boundary();
    for (int i = 0; i < 2 * FRAME && (n_m % FRAME) != FRAME - 1; i++) step(1'b0, 32'd0);
  endtask

  // Called just after a rising edge; reset is asserted asynchronously, held, then released.
  task automatic do_reset();
    reset_n    = 1'b0;
    in_reset_m = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset_n    = 1'b1;
    in_reset_m = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    load       = 1'b0;
    value      = 32'd0;
    blank_mask = 8'h00;
    lz_en      = 1'b0;
    in_reset_m = 1'b1;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset_n    = 1'b1;
    in_reset_m = 1'b0;

    idle(FRAME + 8);

    idle_to_slot(3);
    step(1'b1, 32'h12345678);
    idle(FRAME + 4);

    idle_to_slot(1);
    step(1'b1, 32'hAAAAAAAA);
    idle(3);
    step(1'b1, 32'h55555555);
    idle(FRAME + 4);

    idle_to_slot(2);
    step(1'b1, 32'h11111111);
    idle_to_boundary();
    step(1'b1, 32'h22222222);
    idle(8);

    lz_en = 1'b1;
    step(1'b1, 32'h00000450);
    idle(2 * FRAME);
    step(1'b1, 32'h00000000);
    idle(2 * FRAME);
    lz_en      = 1'b0;
    blank_mask = 8'h81;
    idle(FRAME + 4);
    blank_mask = 8'h00;

    idle_to_slot(4);
    step(1'b1, 32'hDEADBEEF);
    idle(2);
    do_reset();
    idle(2 * FRAME);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) blank_mask = 8'($urandom);
      if ($urandom_range(0, 15) == 0) lz_en = 1'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 5) == 0, $urandom >> (4 * $urandom_range(0, 8)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
